// File: rtl/alu_pkg.sv
// Shared operation codes, FSM states and the reserved-opcode check
// used by the multi-cycle ALU and its shift step.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_MUL = 3'b000,
        OP_SLL = 3'b001,
        OP_SRL = 3'b010,
        OP_SRA = 3'b011,
        OP_ROR = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    function automatic logic op_reserved(input logic [2:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step shared by every shift operation; MUL and
// reserved codes pass the value through unchanged.
module shift_step
    import alu_pkg::*;
(
    input  logic [7:0] value,
    input  logic [2:0] op,
    output logic [7:0] next_value
);

    always_comb begin
        next_value = value;
        case (op)
            OP_SLL:  next_value = {value[6:0], 1'b0};
            OP_SRL:  next_value = {1'b0, value[7:1]};
            OP_SRA:  next_value = {value[7], value[7:1]};
            OP_ROR:  next_value = {value[0], value[7:1]};
            default: next_value = value;
        endcase
    end

endmodule

// File: rtl/multi_cycle_alu.sv
// Iterative 8-bit ALU: shift-add multiply and shifts/rotates at one
// bit per cycle, with a one-cycle DONE pulse that qualifies the write.
module multi_cycle_alu
    import alu_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    input  logic [2:0] OP,
    input  logic       START,
    output logic [7:0] RESULT,
    output logic       BUSY,
    output logic       DONE,
    output logic       ZERO
);

    state_t     state, state_nx;
    logic [7:0] opa, opa_nx;
    logic [7:0] opb, opb_nx;
    logic [2:0] opc, opc_nx;
    logic [3:0] count, count_nx;
    logic [7:0] acc, acc_nx;
    logic [7:0] result_nx;
    logic [7:0] step_out;
    logic [7:0] iter_acc;
    logic [3:0] load_count;

    shift_step u_shift_step (
        .value      (acc),
        .op         (opc),
        .next_value (step_out)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            opa    <= '0;
            opb    <= '0;
            opc    <= '0;
            count  <= '0;
            acc    <= '0;
            RESULT <= '0;
        end else begin
            state  <= state_nx;
            opa    <= opa_nx;
            opb    <= opb_nx;
            opc    <= opc_nx;
            count  <= count_nx;
            acc    <= acc_nx;
            RESULT <= result_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        opa_nx     = opa;
        opb_nx     = opb;
        opc_nx     = opc;
        count_nx   = count;
        acc_nx     = acc;
        result_nx  = RESULT;
        BUSY       = (state == S_RUN);
        DONE       = (state == S_FIN);
        ZERO       = (RESULT == '0);
        // MUL adds the shifted multiplicand when the current multiplier LSB is set
        iter_acc   = (opc == OP_MUL) ? (opb[0] ? acc + opa : acc) : step_out;
        load_count = (OP == OP_MUL) ? 4'd8 : {1'b0, DATA2[2:0]};

        case (state)
            S_IDLE, S_FIN: begin
                state_nx = S_IDLE;
                if (START) begin
                    opa_nx   = DATA1;
                    opb_nx   = (OP == OP_MUL) ? DATA2 : {5'b0, DATA2[2:0]};
                    opc_nx   = OP;
                    count_nx = load_count;
                    acc_nx   = (OP == OP_MUL) ? '0 : DATA1;
                    if (load_count == 4'd0 || op_reserved(OP)) begin
                        state_nx  = S_FIN;
                        result_nx = DATA1;
                        count_nx  = '0;
                    end else begin
                        state_nx  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_nx   = iter_acc;
                count_nx = count - 4'd1;
                if (opc == OP_MUL) begin
                    opa_nx = {opa[6:0], 1'b0};
                    opb_nx = {1'b0, opb[7:1]};
                end
                if (count == 4'd1) begin
                    state_nx  = S_FIN;
                    result_nx = iter_acc;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed and randomized checks of multi_cycle_alu against an
// arithmetic reference model of results and latencies.
module tb_multi_cycle_alu;

    logic       CLK;
    logic       RESET;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [2:0] OP;
    logic       START;
    logic [7:0] RESULT;
    logic       BUSY;
    logic       DONE;
    logic       ZERO;

    int tests;
    int fails;
    logic [7:0] prev_result;

    multi_cycle_alu dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .OP     (OP),
        .START  (START),
        .RESULT (RESULT),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ZERO   (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_result(input logic [7:0] a, input logic [7:0] b,
                                                input logic [2:0] op);
        int unsigned n;
        int unsigned prod;
        logic signed [7:0] s;
        n = b % 8;
        s = a;
        prod = a * b;
        case (op)
            3'd0:    return prod[7:0];
            3'd1:    return a << n;
            3'd2:    return a >> n;
            3'd3:    return s >>> n;
            3'd4:    return (a >> n) | (a << (8 - n));
            default: return a;
        endcase
    endfunction

    function automatic int model_latency(input logic [7:0] b, input logic [2:0] op);
        if (op == 3'd0) return 8;
        if (op > 3'd4) return 0;
        return b % 8;
    endfunction

    // Starts one operation from IDLE or FIN, scrambling inputs (including START)
    // while it runs, and checks BUSY/DONE timing and the final RESULT.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [7:0] exp;
        int lat;
        exp = model_result(a, b, op);
        lat = model_latency(b, op);
        DATA1 = a;
        DATA2 = b;
        OP    = op;
        START = 1'b1;
        for (int i = 0; i <= lat; i++) begin
            @(posedge CLK);
            #1;
            if (i < lat) begin
                chk("busy_run", BUSY, 1);
                chk("done_run", DONE, 0);
                chk("result_hold", RESULT, prev_result);
                DATA1 = 8'($urandom);
                DATA2 = 8'($urandom);
                OP    = 3'($urandom);
                START = 1'($urandom);
            end else begin
                chk("done_fin", DONE, 1);
                chk("busy_fin", BUSY, 0);
                chk("result", RESULT, exp);
                chk("zero", ZERO, (exp == 8'd0) ? 8'd1 : 8'd0);
            end
        end
        START = 1'b0;
        prev_result = exp;
    endtask

    task automatic idle_cycles(input int n);
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            chk("idle_done", DONE, 0);
            chk("idle_busy", BUSY, 0);
            chk("idle_result", RESULT, prev_result);
            DATA1 = 8'($urandom);
            DATA2 = 8'($urandom);
            OP    = 3'($urandom);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        prev_result = 8'd0;
        RESET = 1'b1;
        START = 1'b0;
        DATA1 = 8'h00;
        DATA2 = 8'h00;
        OP    = 3'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_result", RESULT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_zero", ZERO, 1);
        RESET = 1'b0;
        idle_cycles(1);

        run_op(8'd13, 8'd11, 3'd0);
        chk("mul_13_11", RESULT, 8'h8F);
        idle_cycles(1);
        run_op(8'd20, 8'd20, 3'd0);
        chk("mul_20_20", RESULT, 8'h90);
        idle_cycles(2);
        run_op(8'd0, 8'd77, 3'd0);
        chk("mul_zero", ZERO, 1);
        idle_cycles(1);
        run_op(8'h90, 8'd3, 3'd3);
        chk("sra_90_3", RESULT, 8'hF2);
        idle_cycles(1);
        run_op(8'h81, 8'd1, 3'd4);
        chk("ror_81_1", RESULT, 8'hC0);
        idle_cycles(1);
        run_op(8'h2B, 8'd0, 3'd1);
        chk("sll_2b_0", RESULT, 8'h2B);
        idle_cycles(1);
        run_op(8'h5A, 8'd6, 3'd6);
        chk("reserved_op", RESULT, 8'h5A);

        // Back-to-back: second START lands on the FIN edge of the first op.
        run_op(8'd3, 8'd5, 3'd0);
        run_op(8'h80, 8'd7, 3'd2);
        chk("srl_80_7_b2b", RESULT, 8'h01);
        idle_cycles(1);

        // Reset during a MUL: three iterations run, reset lands on the fourth edge.
        DATA1 = 8'd200;
        DATA2 = 8'd3;
        OP    = 3'd0;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_abort_busy", BUSY, 1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("abort_busy", BUSY, 0);
        chk("abort_result", RESULT, 0);
        chk("abort_done", DONE, 0);
        chk("abort_zero", ZERO, 1);
        prev_result = 8'd0;
        idle_cycles(10);

        for (int t = 0; t < 60; t++) begin
            run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            idle_cycles($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
